// File: rtl/poly_pkg.sv
// Shared polygon types: coordinate type, loader state encoding and minimum vertex count.
// Reused by the loader and the other polygon blocks.
package poly_pkg;

    typedef logic signed [31:0] coord_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        DRAIN   = 2'd1,
        PENDING = 2'd2
    } loader_state_t;

    localparam int MIN_POLY_VERTICES = 3;

endpackage

// File: rtl/vertex_bank.sv
// MAX_NUM_VERTICES-entry x/y register bank with one indexed write port,
// a full parallel read and a load-all input that overwrites every entry at once.
module vertex_bank
    import poly_pkg::*;
#(
    parameter int MAX_NUM_VERTICES = 32,
    parameter int IDX_W            = $clog2(MAX_NUM_VERTICES)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic signed [31:0]  wr_x,
    input  logic signed [31:0]  wr_y,
    input  logic                load_en,
    input  logic signed [31:0]  load_xs [MAX_NUM_VERTICES],
    input  logic signed [31:0]  load_ys [MAX_NUM_VERTICES],
    output logic signed [31:0]  xs [MAX_NUM_VERTICES],
    output logic signed [31:0]  ys [MAX_NUM_VERTICES]
);

    // Load-all wins over the single write so a commit is always a full-bank copy.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                xs[i] <= load_xs[i];
                ys[i] <= load_ys[i];
            end
        end else if (wr_en) begin
            xs[wr_idx] <= wr_x;
            ys[wr_idx] <= wr_y;
        end
    end

endmodule

// File: rtl/polygon_loader.sv
// Double-buffered polygon loader: vertices stream into a shadow bank and are committed
// atomically to the active bank on frame start. Optional build macro: POLYGON_LOADER_CLAMP_EN.
module polygon_loader
    import poly_pkg::*;
#(
    parameter int MAX_NUM_VERTICES = 32,
    parameter int PIXEL_WIDTH      = 1280,
    parameter int PIXEL_HEIGHT     = 720
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic signed [31:0]  vertex_x_in,
    input  logic signed [31:0]  vertex_y_in,
    input  logic                vertex_valid_in,
    input  logic                vertex_last_in,
    output logic                vertex_ready_out,
    input  logic                frame_start_in,
    output logic signed [31:0]  poly_xs_out [MAX_NUM_VERTICES],
    output logic signed [31:0]  poly_ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES+1)-1:0] num_points_out,
    output logic                pending_out,
    output logic                error_out
);

    localparam int IDX_W = $clog2(MAX_NUM_VERTICES);
    localparam int CNT_W = $clog2(MAX_NUM_VERTICES + 1);

`ifdef POLYGON_LOADER_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    localparam coord_t X_MAX = coord_t'(PIXEL_WIDTH - 1);
    localparam coord_t Y_MAX = coord_t'(PIXEL_HEIGHT - 1);

    function automatic coord_t saturate(input coord_t v, input coord_t hi);
        if (v < 0)
            return '0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    loader_state_t     state;
    logic [IDX_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  shadow_count;

    logic              vld_p0;
    logic              shadow_wr_p0;
    logic              commit_p0;
    coord_t            wr_x_p0;
    coord_t            wr_y_p0;

    coord_t            sh_xs [MAX_NUM_VERTICES];
    coord_t            sh_ys [MAX_NUM_VERTICES];
    coord_t            zero_bank [MAX_NUM_VERTICES];

    assign zero_bank = '{default: '0};

    // ---- accept stage: handshake, optional clamp, shadow write strobe ----
    assign vld_p0       = vertex_valid_in && vertex_ready_out;
    assign shadow_wr_p0 = vld_p0 && (state == LOAD);
    assign wr_x_p0      = CLAMP ? saturate(vertex_x_in, X_MAX) : vertex_x_in;
    assign wr_y_p0      = CLAMP ? saturate(vertex_y_in, Y_MAX) : vertex_y_in;
    assign commit_p0    = (state == PENDING) && frame_start_in &&
                          (shadow_count >= CNT_W'(MIN_POLY_VERTICES));

    vertex_bank #(
        .MAX_NUM_VERTICES (MAX_NUM_VERTICES),
        .IDX_W            (IDX_W)
    ) u_shadow_bank (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .wr_en   (shadow_wr_p0),
        .wr_idx  (wr_idx),
        .wr_x    (wr_x_p0),
        .wr_y    (wr_y_p0),
        .load_en (1'b0),
        .load_xs (zero_bank),
        .load_ys (zero_bank),
        .xs      (sh_xs),
        .ys      (sh_ys)
    );

    vertex_bank #(
        .MAX_NUM_VERTICES (MAX_NUM_VERTICES),
        .IDX_W            (IDX_W)
    ) u_active_bank (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .wr_en   (1'b0),
        .wr_idx  ('0),
        .wr_x    ('0),
        .wr_y    ('0),
        .load_en (commit_p0),
        .load_xs (sh_xs),
        .load_ys (sh_ys),
        .xs      (poly_xs_out),
        .ys      (poly_ys_out)
    );

    // ---- control stage: registered state, handshake and status outputs ----
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= LOAD;
            wr_idx           <= '0;
            shadow_count     <= '0;
            num_points_out   <= '0;
            vertex_ready_out <= 1'b1;
            pending_out      <= 1'b0;
            error_out        <= 1'b0;
        end else begin
            error_out <= 1'b0;
            case (state)
                LOAD: begin
                    if (vld_p0) begin
                        if (vertex_last_in) begin
                            shadow_count     <= CNT_W'(wr_idx) + CNT_W'(1);
                            state            <= PENDING;
                            vertex_ready_out <= 1'b0;
                            pending_out      <= 1'b1;
                        end else if (wr_idx == IDX_W'(MAX_NUM_VERTICES - 1)) begin
                            // Bank full without a last flag: keep what fits, drop the rest.
                            shadow_count <= CNT_W'(MAX_NUM_VERTICES);
                            error_out    <= 1'b1;
                            state        <= DRAIN;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (vld_p0 && vertex_last_in) begin
                        state            <= PENDING;
                        vertex_ready_out <= 1'b0;
                        pending_out      <= 1'b1;
                    end
                end
                PENDING: begin
                    if (frame_start_in) begin
                        if (commit_p0)
                            num_points_out <= shadow_count;
                        else
                            error_out <= 1'b1;
                        wr_idx           <= '0;
                        state            <= LOAD;
                        vertex_ready_out <= 1'b1;
                        pending_out      <= 1'b0;
                    end
                end
                default: begin
                    state            <= LOAD;
                    wr_idx           <= '0;
                    vertex_ready_out <= 1'b1;
                    pending_out      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polygon_loader.sv
// Directed bench for polygon_loader: reset, commit timing, truncation, degenerate
// rejection, coincident frame start, clamp behaviour and asynchronous reset.
module tb_polygon_loader;

    localparam int N = 32;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic signed [31:0] vertex_x_in = '0;
    logic signed [31:0] vertex_y_in = '0;
    logic               vertex_valid_in = 1'b0;
    logic               vertex_last_in = 1'b0;
    logic               vertex_ready_out;
    logic               frame_start_in = 1'b0;
    logic signed [31:0] poly_xs_out [N];
    logic signed [31:0] poly_ys_out [N];
    logic [5:0]         num_points_out;
    logic               pending_out;
    logic               error_out;

    int tests = 0;
    int fails = 0;

    polygon_loader #(
        .MAX_NUM_VERTICES (N),
        .PIXEL_WIDTH      (1280),
        .PIXEL_HEIGHT     (720)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .vertex_x_in      (vertex_x_in),
        .vertex_y_in      (vertex_y_in),
        .vertex_valid_in  (vertex_valid_in),
        .vertex_last_in   (vertex_last_in),
        .vertex_ready_out (vertex_ready_out),
        .frame_start_in   (frame_start_in),
        .poly_xs_out      (poly_xs_out),
        .poly_ys_out      (poly_ys_out),
        .num_points_out   (num_points_out),
        .pending_out      (pending_out),
        .error_out        (error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input int x, input int y, input logic last, input logic fs);
        vertex_x_in     = x;
        vertex_y_in     = y;
        vertex_last_in  = last;
        vertex_valid_in = 1'b1;
        frame_start_in  = fs;
        step();
        vertex_valid_in = 1'b0;
        vertex_last_in  = 1'b0;
        frame_start_in  = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start_in = 1'b1;
        step();
        frame_start_in = 1'b0;
    endtask

    initial begin
        int nonzero;
        int err_pulses;
        int err_at;
        int exp_x0;
        int exp_y0;

        // Reset state
        step();
        step();
        rst_in = 1'b0;
        step();
        nonzero = 0;
        for (int i = 0; i < N; i++)
            if (poly_xs_out[i] !== 0 || poly_ys_out[i] !== 0) nonzero++;
        check("rst_arrays_nonzero", nonzero, 0);
        check("rst_num_points", num_points_out, 0);
        check("rst_ready", vertex_ready_out, 1);
        check("rst_pending", pending_out, 0);
        check("rst_error", error_out, 0);

        // Square: pending after last, active untouched until frame start
        send(100, 100, 1'b0, 1'b0);
        send(200, 100, 1'b0, 1'b0);
        send(200, 200, 1'b0, 1'b0);
        send(100, 200, 1'b1, 1'b0);
        check("sq_pending", pending_out, 1);
        check("sq_ready_low", vertex_ready_out, 0);
        check("sq_pre_commit_count", num_points_out, 0);
        check("sq_pre_commit_x0", poly_xs_out[0], 0);
        step();
        step();
        check("sq_still_uncommitted", num_points_out, 0);
        pulse_frame();
        check("sq_count", num_points_out, 4);
        check("sq_x0", poly_xs_out[0], 100);
        check("sq_y0", poly_ys_out[0], 100);
        check("sq_x1", poly_xs_out[1], 200);
        check("sq_y2", poly_ys_out[2], 200);
        check("sq_x3", poly_xs_out[3], 100);
        check("sq_y3", poly_ys_out[3], 200);
        check("sq_ready_back", vertex_ready_out, 1);
        check("sq_pending_clear", pending_out, 0);
        step();
        check("sq_persist", num_points_out, 4);

        // Truncation: 34 vertices into a 32-entry bank
        err_pulses = 0;
        err_at = -1;
        for (int i = 0; i < 34; i++) begin
            send(i * 10, i * 10 + 1, (i == 33), 1'b0);
            if (error_out === 1'b1) begin
                err_pulses++;
                err_at = i;
            end
            if (i == 32) check("trunc_ready_in_drain", vertex_ready_out, 1);
        end
        check("trunc_err_pulses", err_pulses, 1);
        check("trunc_err_index", err_at, 31);
        check("trunc_pending", pending_out, 1);
        check("trunc_active_kept", num_points_out, 4);
        pulse_frame();
        check("trunc_count", num_points_out, 32);
        check("trunc_x0", poly_xs_out[0], 0);
        check("trunc_x31", poly_xs_out[31], 310);
        check("trunc_y31", poly_ys_out[31], 311);
        check("trunc_commit_no_err", error_out, 0);

        // Degenerate 2-vertex polygon
        send(7, 8, 1'b0, 1'b0);
        send(9, 10, 1'b1, 1'b0);
        check("degen_pending", pending_out, 1);
        pulse_frame();
        check("degen_error", error_out, 1);
        check("degen_count_kept", num_points_out, 32);
        check("degen_x1_kept", poly_xs_out[1], 10);
        check("degen_y0_kept", poly_ys_out[0], 1);
        check("degen_ready", vertex_ready_out, 1);
        check("degen_pending_clear", pending_out, 0);
        step();
        check("degen_error_one_cycle", error_out, 0);

        // Frame start coincident with last accept does not commit
        send(300, 300, 1'b0, 1'b0);
        send(400, 300, 1'b0, 1'b0);
        send(350, 400, 1'b1, 1'b1);
        check("coinc_pending", pending_out, 1);
        check("coinc_no_commit", num_points_out, 32);
        pulse_frame();
        check("coinc_count", num_points_out, 3);
        check("coinc_x2", poly_xs_out[2], 350);
        check("coinc_y2", poly_ys_out[2], 400);
        check("coinc_stale_x3", poly_xs_out[3], 30);

        // Off-screen vertex: clamped or stored verbatim depending on build
`ifdef POLYGON_LOADER_CLAMP_EN
        exp_x0 = 0;
        exp_y0 = 719;
`else
        exp_x0 = -50;
        exp_y0 = 900;
`endif
        send(-50, 900, 1'b0, 1'b0);
        send(10, 20, 1'b0, 1'b0);
        send(30, 40, 1'b1, 1'b0);
        pulse_frame();
        check("clamp_count", num_points_out, 3);
        check("clamp_x0", poly_xs_out[0], exp_x0);
        check("clamp_y0", poly_ys_out[0], exp_y0);
        check("clamp_x1", poly_xs_out[1], 10);

        // Asynchronous reset while pending
        send(1, 2, 1'b0, 1'b0);
        send(3, 4, 1'b0, 1'b0);
        send(5, 6, 1'b1, 1'b0);
        check("arst_pre_pending", pending_out, 1);
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_pending", pending_out, 0);
        check("arst_ready", vertex_ready_out, 1);
        check("arst_count", num_points_out, 0);
        check("arst_x0", poly_xs_out[0], 0);
        step();
        rst_in = 1'b0;
        step();
        pulse_frame();
        check("arst_no_commit", num_points_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/polygon_loader.md
# polygon_loader

Streams polygon vertices in over a valid/ready handshake, buffers them in a shadow bank and, on the next frame-start pulse, commits the whole polygon atomically to the parallel vertex arrays and vertex count consumed by the point-in-polygon tester. It sits between the physics/vertex-update logic and the per-pixel polygon tester. The tester therefore never sees a half-written polygon mid-frame.

## Interface

Parameters:

- MAX_NUM_VERTICES, 32: capacity of each bank.
- PIXEL_WIDTH, 1280: horizontal clamp bound (clamp build only).
- PIXEL_HEIGHT, 720: vertical clamp bound (clamp build only).

Ports:

- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-high.
- vertex_x_in  input  32 signed  vertex x coordinate.
- vertex_y_in  input  32 signed  vertex y coordinate.
- vertex_valid_in  input  1  vertex present.
- vertex_last_in  input  1  marks the final vertex of the polygon.
- vertex_ready_out  output  1  loader accepts a vertex this cycle.
- frame_start_in  input  1  single-cycle pulse; the only commit point.
- poly_xs_out  output  32 signed x MAX_NUM_VERTICES  active x array.
- poly_ys_out  output  32 signed x MAX_NUM_VERTICES  active y array.
- num_points_out  output  $clog2(MAX_NUM_VERTICES+1)  active vertex count.
- pending_out  output  1  shadow polygon complete, awaiting commit.
- error_out  output  1  one-cycle pulse on truncation or a degenerate polygon.

## Operation

- Transfer: a vertex is accepted when vertex_valid_in && vertex_ready_out are both high at a rising edge.
- States:
  - LOAD:
    - vertex_ready_out=1.
    - Each accepted vertex writes shadow[wr_idx]; wr_idx increments.
    - On accept with last=1: go to PENDING; shadow_count = wr_idx+1.
    - On accept with last=0 at wr_idx==MAX_NUM_VERTICES-1: truncate. Set shadow_count=MAX_NUM_VERTICES, pulse error_out, go to DRAIN.
  - DRAIN:
    - vertex_ready_out=1.
    - Accepted vertices are discarded.
    - An accept with last=1 goes to PENDING.
  - PENDING:
    - vertex_ready_out=0; pending_out=1.
    - On frame_start_in:
      - If shadow_count>=3: copy the shadow bank to the active bank and set num_points_out=shadow_count.
      - Otherwise the polygon is degenerate: pulse error_out and leave the active bank unchanged.
    - In both cases reset wr_idx=0 and return to LOAD.
- frame_start_in in LOAD or DRAIN is ignored. The active polygon persists across any number of frames.
- Active-bank entries at index >= num_points_out keep stale values. Consumers must mask them using the count.
- Single-vertex polygon (last on the first vertex): the polygon is complete; it is rejected at commit as degenerate.

## Timing

- Reset values:
  - state=LOAD, wr_idx=0.
  - vertex_ready_out=1, pending_out=0, error_out=0.
  - num_points_out=0; all poly_xs_out/poly_ys_out entries 0.
  - A count of 0 makes every pixel test "outside".
- Reset asserted mid-load or while pending discards the shadow contents immediately (asynchronous).
- Throughput: one vertex per cycle in LOAD and DRAIN.
- vertex_ready_out is a registered function of state only, with no combinational path from inputs.
- Last vertex accepted at edge N: pending_out=1 and vertex_ready_out=0 from cycle N+1.
- Commit:
  - frame_start_in high at edge M in PENDING: new arrays and count are visible from cycle M+1.
  - vertex_ready_out returns high at M+1.
- frame_start_in coincident with the last-vertex accept: no commit. The commit happens on the next frame_start_in.
- error_out:
  - Truncation: high for exactly the cycle after the offending accept.
  - Degenerate polygon: high for exactly the cycle after the offending frame_start_in.
- Outputs are registered. The active bank changes only on the commit cycle.

## Configuration

- POLYGON_LOADER_CLAMP_EN:
  - Defined: accepted coordinates are saturated to x in [0, PIXEL_WIDTH-1] and y in [0, PIXEL_HEIGHT-1] before the shadow write. This is a signed compare.
  - Undefined: coordinates are stored unmodified, including negative and off-screen values.
  - Handshake and timing are identical in both builds.

## Structure

- Shared package poly_pkg holds:
  - typedef coord_t (logic signed [31:0]).
  - The loader state enum {LOAD, DRAIN, PENDING}.
  - The MIN_POLY_VERTICES=3 constant.
  - Other polygon blocks reuse these items.
- Sub-module vertex_bank:
  - MAX_NUM_VERTICES-entry x/y register array.
  - One write port (index, enable).
  - Full parallel read plus a load-all input.
  - Instantiated once for the shadow bank and once for the active bank.
- All control lives in polygon_loader.

## Test plan

- Reset, then read the outputs: num_points_out=0, all array entries 0, vertex_ready_out=1, pending_out=0.
- Load the 4-vertex square (100,100),(200,100),(200,200),(100,200) with last on the 4th vertex:
  - pending_out=1 and ready=0 the cycle after.
  - Arrays unchanged until frame_start_in; num_points_out=4 and the arrays match one cycle after the pulse.
- Stream 34 vertices into MAX_NUM_VERTICES=32:
  - error_out pulses once after the 32nd accept.
  - Vertices 33–34 are accepted and dropped.
  - Commit gives num_points_out=32.
- Send 2 vertices with last, then frame_start_in: error_out pulses, the active polygon from the previous test is unchanged, and ready=1.
- frame_start_in in the same cycle as the last accept: no commit. The commit occurs on the next pulse.
- With POLYGON_LOADER_CLAMP_EN defined, load vertex (-50, 900): it is stored as (0, 719). Without the macro it is stored as (-50, 900).
